slice_ring_ctrl: RTL
====================

// Module: slice_ring_ctrl
// PURPOSE
//  Schedules the slice RAM as a ring of SLOTS image slots shared by one writer (RGB capture) and one reader (LED driver).
//  Generates the writer's RAM address, commits full slices, and grants completed slices to the reader.
//  Raises stream_ready once PREFILL slices are buffered. Sits between RGB capture, RAM and driver sequencer.
// PARAMETERS
//  RAM_ADDR_WIDTH  32    RAM address width
//  IMAGE_SIZE      1920  pixels per slice (40x48)
//  SLOTS           18    slices held in RAM
//  PREFILL         1     committed slices required before streaming
// PORTS
//  rgb_clk       in   1               single clock, all logic posedge
//  nrst          in   1               async active-low reset
//  rgb_enable    in   1               SPI start; low = flush to IDLE
//  wr_pixel      in   1               writer wrote one pixel this cycle
//  wr_allow      out  1               writer may write (not IDLE, ring not full)
//  wr_addr       out  RAM_ADDR_WIDTH  address for current pixel = wr_base + wr_pix
//  rd_req        in   1               driver wants a slice (level)
//  rd_grant      out  1               1-cycle pulse: rd_base valid, slice held
//  rd_base       out  RAM_ADDR_WIDTH  base address of granted slice
//  rd_done       in   1               driver released held slice (pulse)
//  stream_ready  out  1               state == STREAM
//  underrun      out  1               1-cycle pulse: rd_req, nothing to grant, in STREAM
//  fill_level    out  $clog2(SLOTS+1) committed slots incl. held slot
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wr_slot=rd_slot=0, wr_pix=0, count=0, holding=0.
//  FSM: IDLE -(rgb_enable)-> FILL -(count>=PREFILL)-> STREAM. Any state -(!rgb_enable)-> IDLE next cycle,
//   synchronously clearing pointers, count, holding, wr_pix (identical to reset values).
//  Write: wr_pixel && wr_allow -> wr_pix++. wr_pixel when !wr_allow is ignored (no state change).
//  Commit: accepted pixel at wr_pix==IMAGE_SIZE-1 -> wr_pix=0, wr_slot wraps SLOTS-1->0, count++.
//  wr_base = wr_slot*IMAGE_SIZE, registered; updates cycle after commit; wr_addr combinational from regs.
//  Full: count==SLOTS -> wr_allow=0 until a release.
//  Grant: state==STREAM && rd_req && !holding && (count - holding)>0 -> rd_grant=1 one cycle,
//   rd_base<=rd_slot*IMAGE_SIZE same edge, holding=1. No new grant while holding, even with rd_req high.
//  Release: rd_done && holding -> holding=0, rd_slot wraps, count--. rd_done with !holding ignored.
//  Grant and release in same cycle impossible (grant requires !holding).
//  Commit + release same cycle: count unchanged, both pointers advance.
//  underrun: STREAM && rd_req && !holding && count==0; stays in STREAM.
//  Latency: rd_req high -> rd_grant on next edge (1 cycle). Commit -> fill_level +1 next cycle.
//  Arithmetic: count width $clog2(SLOTS+1); slot indices $clog2(SLOTS); base multiply by constant.
// CONFIGURATION
//  RING_STATS_EN defined: adds output drop_cnt [15:0] counting wr_pixel while !wr_allow and rgb_enable;
//   saturates at 16'hFFFF; cleared on reset and in IDLE.
//  Undefined: no drop_cnt port or logic; all else identical.
// STRUCTURE
//  Shared package spirose_ram_pkg: IMAGE_WIDTH=40, IMAGE_HEIGHT=48, IMAGE_SIZE, slot index typedef,
//   ring_state_e {IDLE, FILL, STREAM}.
//  Sub-module wrap_counter #(MAX): enable/clear modulo counter, used for wr_slot, rd_slot, wr_pix.
// TESTING
//  Reset mid-stream (nrst low during STREAM) -> all outputs 0, IDLE; after release, rgb_enable=1 -> FILL.
//  1920 wr_pixel with PREFILL=1 -> fill_level=1, stream_ready=1 next cycle, wr_addr=1920.
//  rd_req after one slice -> rd_grant 1 cycle later, rd_base=0; rd_done -> fill_level=0, next rd_req -> underrun pulse.
//  18 slices written, no reads -> wr_allow=0, fill_level=18; further wr_pixel ignored, wr_addr frozen at 0.
//  Commit and rd_done same cycle at fill_level=3 -> fill_level stays 3, wr_slot and rd_slot both +1.
//  Wrap: wr_slot 17 commit -> wr_addr=0; rgb_enable low mid-slice -> IDLE, fill_level=0, wr_addr=0;
//   with RING_STATS_EN, 5 pixels while full -> drop_cnt=5.

Source files
------------

// File: rtl/spirose_ram_pkg.sv
// Shared constants and types for the spirose slice RAM: image geometry,
// ring slot index type and ring controller states.
package spirose_ram_pkg;

  localparam int IMAGE_WIDTH  = 40;
  localparam int IMAGE_HEIGHT = 48;
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int RING_SLOTS   = 18;

  typedef logic [$clog2(RING_SLOTS)-1:0] slot_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } ring_state_e;

  // RAM base address of a slot: slot index times slice size.
  function automatic logic [31:0] slot_base(input logic [31:0] slot, input logic [31:0] size);
    slot_base = slot * size;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with synchronous clear (priority) and count enable.
// Counts 0..MAX-1 and wraps back to 0.
module wrap_counter #(
  parameter int MAX = 2,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         rgb_clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] value_r;
  logic [W-1:0] value_s;

  // Next count: clear wins, then wrap-or-increment when enabled.
  always_comb begin
    value_s = value_r;
    if (clr) begin
      value_s = '0;
    end else if (en) begin
      if (value_r == LAST) begin
        value_s = '0;
      end else begin
        value_s = value_r + W'(1);
      end
    end else begin
      value_s = value_r;
    end
  end

  // Count register.
  always_ff @(posedge rgb_clk or negedge nrst) begin
    if (!nrst) begin
      value_r <= '0;
    end else begin
      value_r <= value_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/slice_ring_ctrl.sv
// Ring scheduler for the slice RAM: one capture writer, one LED-driver reader.
// Optional macro RING_STATS_EN adds a saturating drop_cnt of rejected pixels.
module slice_ring_ctrl #(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int IMAGE_SIZE     = spirose_ram_pkg::IMAGE_SIZE,
  parameter int SLOTS          = spirose_ram_pkg::RING_SLOTS,
  parameter int PREFILL        = 1
) (
  input  logic                       rgb_clk,
  input  logic                       nrst,
  input  logic                       rgb_enable,
  input  logic                       wr_pixel,
  output logic                       wr_allow,
  output logic [RAM_ADDR_WIDTH-1:0]  wr_addr,
  input  logic                       rd_req,
  output logic                       rd_grant,
  output logic [RAM_ADDR_WIDTH-1:0]  rd_base,
  input  logic                       rd_done,
  output logic                       stream_ready,
  output logic                       underrun,
  output logic [$clog2(SLOTS+1)-1:0] fill_level
`ifdef RING_STATS_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  import spirose_ram_pkg::*;

  localparam int CW = $clog2(SLOTS + 1);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [PW-1:0] PIX_LAST      = PW'(IMAGE_SIZE - 1);
  localparam logic [SW-1:0] SLOT_LAST     = SW'(SLOTS - 1);
  localparam logic [CW-1:0] COUNT_FULL    = CW'(SLOTS);
  localparam logic [CW-1:0] COUNT_PREFILL = CW'(PREFILL);

  ring_state_e               state_r, state_s;
  logic [CW-1:0]             count_r, count_s;
  logic                      holding_r, holding_s;
  logic                      wr_allow_r, rd_grant_r, underrun_r, stream_ready_r;
  logic [RAM_ADDR_WIDTH-1:0] wr_base_r, wr_base_s, rd_base_r, rd_base_s;
  logic [PW-1:0]             wr_pix_s;
  logic [SW-1:0]             wr_slot_s, rd_slot_s, wr_slot_nxt_s;
  logic                      flush_s, accept_s, commit_s, release_s, grant_s, underrun_s;

  wrap_counter #(.MAX(IMAGE_SIZE), .W(PW)) u_wr_pix (
    .rgb_clk (rgb_clk), .nrst (nrst), .clr (flush_s), .en (accept_s), .value (wr_pix_s)
  );

  wrap_counter #(.MAX(SLOTS), .W(SW)) u_wr_slot (
    .rgb_clk (rgb_clk), .nrst (nrst), .clr (flush_s), .en (commit_s), .value (wr_slot_s)
  );

  wrap_counter #(.MAX(SLOTS), .W(SW)) u_rd_slot (
    .rgb_clk (rgb_clk), .nrst (nrst), .clr (flush_s), .en (release_s), .value (rd_slot_s)
  );

  // Per-cycle events; holding implies count >= 1, so count - holding > 0 reduces to count != 0.
  always_comb begin
    flush_s    = !rgb_enable;
    accept_s   = wr_pixel && wr_allow_r;
    commit_s   = accept_s && (wr_pix_s == PIX_LAST);
    release_s  = rd_done && holding_r;
    grant_s    = rgb_enable && (state_r == STREAM) && rd_req && !holding_r && (count_r != '0);
    underrun_s = rgb_enable && (state_r == STREAM) && rd_req && !holding_r && (count_r == '0);
  end

  // Ring state machine next-state.
  always_comb begin
    state_s = state_r;
    if (flush_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:   state_s = FILL;
        FILL: begin
          if (count_r >= COUNT_PREFILL) begin
            state_s = STREAM;
          end else begin
            state_s = FILL;
          end
        end
        STREAM: state_s = STREAM;
        default: state_s = IDLE;
      endcase
    end
  end

  // Occupancy, hold flag and slot base addresses; wr_base follows the slot being entered.
  always_comb begin
    count_s       = count_r;
    holding_s     = holding_r;
    wr_base_s     = wr_base_r;
    rd_base_s     = rd_base_r;
    wr_slot_nxt_s = wr_slot_s;
    if (flush_s) begin
      count_s       = '0;
      holding_s     = 1'b0;
      wr_base_s     = '0;
      rd_base_s     = '0;
      wr_slot_nxt_s = '0;
    end else begin
      case ({commit_s, release_s})
        2'b10:   count_s = count_r + CW'(1);
        2'b01:   count_s = count_r - CW'(1);
        default: count_s = count_r;
      endcase
      if (commit_s) begin
        if (wr_slot_s == SLOT_LAST) begin
          wr_slot_nxt_s = '0;
        end else begin
          wr_slot_nxt_s = wr_slot_s + SW'(1);
        end
        wr_base_s = RAM_ADDR_WIDTH'(slot_base(32'(wr_slot_nxt_s), 32'(IMAGE_SIZE)));
      end else begin
        wr_base_s = wr_base_r;
      end
      if (grant_s) begin
        holding_s = 1'b1;
        rd_base_s = RAM_ADDR_WIDTH'(slot_base(32'(rd_slot_s), 32'(IMAGE_SIZE)));
      end else if (release_s) begin
        holding_s = 1'b0;
      end else begin
        holding_s = holding_r;
      end
    end
  end

  // State and registered outputs; wr_allow/stream_ready are precomputed from next values.
  always_ff @(posedge rgb_clk or negedge nrst) begin
    if (!nrst) begin
      state_r        <= IDLE;
      count_r        <= '0;
      holding_r      <= 1'b0;
      wr_base_r      <= '0;
      rd_base_r      <= '0;
      wr_allow_r     <= 1'b0;
      stream_ready_r <= 1'b0;
      rd_grant_r     <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      count_r        <= count_s;
      holding_r      <= holding_s;
      wr_base_r      <= wr_base_s;
      rd_base_r      <= rd_base_s;
      wr_allow_r     <= (state_s != IDLE) && (count_s != COUNT_FULL);
      stream_ready_r <= (state_s == STREAM);
      rd_grant_r     <= grant_s;
      underrun_r     <= underrun_s;
    end
  end

`ifdef RING_STATS_EN
  logic [15:0] drop_cnt_r;

  // Saturating count of pixels offered while the ring refused them.
  always_ff @(posedge rgb_clk or negedge nrst) begin
    if (!nrst) begin
      drop_cnt_r <= 16'h0000;
    end else if (state_r == IDLE) begin
      drop_cnt_r <= 16'h0000;
    end else if (wr_pixel && !wr_allow_r && rgb_enable && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign wr_allow     = wr_allow_r;
  assign wr_addr      = wr_base_r + RAM_ADDR_WIDTH'(wr_pix_s);
  assign rd_grant     = rd_grant_r;
  assign rd_base      = rd_base_r;
  assign stream_ready = stream_ready_r;
  assign underrun     = underrun_r;
  assign fill_level   = count_r;

endmodule
